// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- multi-cycle 32/32 restoring divider for the EX stage.
//
// One quotient bit is produced per clock. A division is requested by holding
// start_i high; the operands are sampled only on the edge that accepts the
// request. The result is held on result_o with ready_o high for as long as
// start_i stays high, and is cleared once start_i drops.
//
// Latency, counted from the start-sampling edge:
//   non-zero divisor : ready_o rises on edge 33 (32 restoring steps + fix-up)
//   zero divisor     : ready_o rises on edge 2, result_o = 0 (no trap)
//
// Optional feature macro:
//   DIV_SIGNED_EN  defined   -> signed_div_i selects two's-complement division
//                               (magnitudes divided, signs fixed up afterwards)
//                  undefined -> every division is unsigned, signed_div_i ignored
//
// Ports:
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous reset, active low
//   signed_div_i  in   1   1 = signed division, 0 = unsigned
//   opdata1_i     in  32   dividend
//   opdata2_i     in  32   divisor
//   start_i       in   1   division request, held until ready_o is seen
//   annul_i       in   1   abort the division in flight (pipeline flush)
//   result_o      out 64   {remainder, quotient}
//   ready_o       out  1   result_o valid
//   busy_o        out  1   division in progress (feeds the EX stall request)
// -----------------------------------------------------------------------------
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  localparam logic [5:0] LP_STEPS = 6'd32;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // One restoring step. The top dividend bit (quo[31]) is shifted into the
  // partial remainder and the divisor magnitude is trial-subtracted. Because
  // the partial remainder is always below the divisor, the 33-bit difference
  // has bit 32 set exactly when the subtraction went negative.
  // Returns {next_remainder, next_quotient_shift_register}.
  function automatic logic [63:0] restoring_step(
    input logic [31:0] rem,
    input logic [31:0] quo,
    input logic [31:0] dvs
  );
    logic [32:0] w_trial;
    w_trial = {rem, quo[31]} - {1'b0, dvs};
    if (w_trial[32]) begin
      restoring_step = {rem[30:0], quo[31], quo[30:0], 1'b0};
    end else begin
      restoring_step = {w_trial[31:0], quo[30:0], 1'b1};
    end
  endfunction

`ifdef DIV_SIGNED_EN
  // Two's-complement negation; -0x80000000 wraps to itself, which is exactly
  // the magnitude the unsigned core needs for the most negative operand.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;     // partial remainder
  logic [31:0] r_quo;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [31:0] r_dvs;     // divisor magnitude
  logic [63:0] r_result;
  logic        r_ready;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [5:0]  w_cnt_nxt;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_dvs_nxt;
  logic [63:0] w_result_nxt;
  logic        w_ready_nxt;
  logic        w_busy_nxt;

  logic        w_accept;
  logic [63:0] w_step;
  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_accept = start_i & ~annul_i;
  assign w_step   = restoring_step(r_rem, r_quo, r_dvs);

  // ---------------------------------------------------------------------------
  // Sign handling (present only in the signed build)
  // ---------------------------------------------------------------------------
`ifdef DIV_SIGNED_EN
  logic w_op1_neg;
  logic w_op2_neg;
  logic r_neg_quo;   // quotient must be negated: operand signs differ
  logic r_neg_rem;   // remainder must be negated: dividend was negative

  assign w_op1_neg = signed_div_i & opdata1_i[31];
  assign w_op2_neg = signed_div_i & opdata2_i[31];
  assign w_op1_mag = w_op1_neg ? neg32(opdata1_i) : opdata1_i;
  assign w_op2_mag = w_op2_neg ? neg32(opdata2_i) : opdata2_i;
  assign w_quo_fix = r_neg_quo ? neg32(r_quo) : r_quo;
  assign w_rem_fix = r_neg_rem ? neg32(r_rem) : r_rem;

  // Capture the sign fix-up flags on the start-sampling edge only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if ((r_state == ST_FREE) && w_accept) begin
      r_neg_quo <= w_op1_neg ^ w_op2_neg;
      r_neg_rem <= w_op1_neg;
    end else begin
      r_neg_quo <= r_neg_quo;
      r_neg_rem <= r_neg_rem;
    end
  end
`else
  logic w_unused_signed;

  assign w_op1_mag       = opdata1_i;
  assign w_op2_mag       = opdata2_i;
  assign w_quo_fix       = r_quo;
  assign w_rem_fix       = r_rem;
  assign w_unused_signed = signed_div_i;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------

  // FSM transitions and datapath updates; every target starts from "hold".
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dvs_nxt    = r_dvs;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;

    case (r_state)
      ST_FREE: begin
        w_ready_nxt  = 1'b0;
        w_result_nxt = 64'd0;
        if (w_accept) begin
          if (opdata2_i == 32'd0) begin
            w_state_nxt = ST_BYZERO;
          end else begin
            w_state_nxt = ST_ON;
            w_cnt_nxt   = 6'd0;
            w_rem_nxt   = 32'd0;
            w_quo_nxt   = w_op1_mag;
            w_dvs_nxt   = w_op2_mag;
          end
        end else begin
          w_state_nxt = ST_FREE;
        end
      end

      // Divide-by-zero: produce a zero result instead of trapping. ready_o is
      // raised by END on the following edge, giving the two-edge latency.
      ST_BYZERO: begin
        w_result_nxt = 64'd0;
        w_ready_nxt  = 1'b0;
        if (annul_i) begin
          w_state_nxt = ST_FREE;
        end else begin
          w_state_nxt = ST_END;
        end
      end

      ST_ON: begin
        if (annul_i) begin
          w_state_nxt  = ST_FREE;
          w_result_nxt = 64'd0;
          w_ready_nxt  = 1'b0;
          w_cnt_nxt    = 6'd0;
        end else if (r_cnt != LP_STEPS) begin
          w_rem_nxt = w_step[63:32];
          w_quo_nxt = w_step[31:0];
          w_cnt_nxt = r_cnt + 6'd1;
        end else begin
          // All 32 bits done: apply sign fix-up and present the result now,
          // so ready_o rises on the same edge that enters END.
          w_state_nxt  = ST_END;
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = 1'b1;
          w_cnt_nxt    = 6'd0;
        end
      end

      // Result held while EX keeps start_i high; a still-high start_i is the
      // same request, never a new one.
      ST_END: begin
        if (start_i) begin
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt  = ST_FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = 64'd0;
        end
      end

      default: begin
        w_state_nxt  = ST_FREE;
        w_cnt_nxt    = 6'd0;
        w_ready_nxt  = 1'b0;
        w_result_nxt = 64'd0;
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == ST_ON) || (w_state_nxt == ST_BYZERO);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // FSM state and iteration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FREE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Datapath: partial remainder, quotient shift register, divisor magnitude.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem <= 32'd0;
      r_quo <= 32'd0;
      r_dvs <= 32'd0;
    end else begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_dvs <= w_dvs_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= 64'd0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- self-checking bench for div_seq.
// Expected results are pushed to a scoreboard queue when a division is driven
// and popped when ready_o is observed. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int          n_checks;
  int          n_pass;
  logic [63:0] sb_q[$];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference divider written from the arithmetic definition.
  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic        use_s;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    use_s = sgn;
`else
    use_s = sgn & 1'b0;
`endif
    ma = (use_s && a[31]) ? (32'd0 - a) : a;
    mb = (use_s && b[31]) ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (use_s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (use_s && a[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  // Full transaction: request, latency/busy tracking, result hold, release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_v);
    int          edges;
    int          exp_lat;
    logic        busy_ok;
    logic [63:0] got_exp;
    exp_lat = (b == 32'd0) ? 2 : 33;
    sb_q.push_back(exp_v);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);              // start-sampling edge
    #1;
    check_val({tag, "_busy_e0"}, {63'd0, busy_o}, 64'd1);
    opdata1_i = $urandom;        // operands must be ignored from here on
    opdata2_i = $urandom;
    signed_div_i = ~sgn;
    edges   = 0;
    busy_ok = 1'b1;
    while (!ready_o && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (!ready_o && (b != 32'd0) && (busy_o !== 1'b1)) busy_ok = 1'b0;
    end
    check_val({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    check_val({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
    check_val({tag, "_busy_end"}, {63'd0, busy_o}, 64'd0);
    if (sb_q.size() > 0) got_exp = sb_q.pop_front();
    else got_exp = 64'hDEAD_DEAD_DEAD_DEAD;
    check_val({tag, "_result"}, result_o, got_exp);
    // start still high: result held, no new division accepted
    @(posedge clk);
    #1;
    check_val({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
    check_val({tag, "_hold_res"}, result_o, got_exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_val({tag, "_rel_rdy"}, {63'd0, ready_o}, 64'd0);
    check_val({tag, "_rel_res"}, result_o, 64'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic        rdy_seen;
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #2;
    check_val("rst_result", result_o, 64'd0);
    check_val("rst_ready", {63'd0, ready_o}, 64'd0);
    check_val("rst_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
`else
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
`endif
    run_div("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC);
    run_div("byzero", 1'b0, 32'h12345678, 32'd0, 64'd0);
    run_div("big_small", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    run_div("small_big", 1'b0, 32'd5, 32'hFFFFFFFE, 64'h00000005_00000000);

    // Annul in flight at cnt = 10.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_val("annul_busy", {63'd0, busy_o}, 64'd0);
    check_val("annul_res", result_o, 64'd0);
    rdy_seen = ready_o;
    @(negedge clk);
    annul_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      rdy_seen = rdy_seen | ready_o;
    end
    check_val("annul_rdy", {63'd0, rdy_seen}, 64'd0);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Reset mid-division at cnt = 20, between edges.
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_res", result_o, 64'd0);
    check_val("midrst_rdy", {63'd0, ready_o}, 64'd0);
    check_val("midrst_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b1;
    run_div("after_rst", 1'b0, 32'd1, 32'd1, 64'h00000000_00000001);

    // Random operands checked against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 1) ? $urandom : 32'($urandom_range(1, 255));
      rs = 1'($urandom_range(0, 1));
      run_div("rand", rs, ra, rb, model_div(rs, ra, rb));
    end

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
